axil_reg_bank: RTL and testbench

AXIL_REG_BANK -- requirements
Module: axil_reg_bank

---
 rtl/axil_reg_bank.sv | 229 ++++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bank.sv
// AXI4 (single-beat) slave register bank: CTRL start pulse, STATUS busy/sticky-done, CFG registers.
// Define AXIL_REG_BANK_DECERR_EN to turn out-of-range accesses into SLVERR instead of aliasing.
module axil_reg_bank #(
  parameter int unsigned S_AXI_ADDR_WIDTH = 40,
  parameter int unsigned S_AXI_DATA_WIDTH = 32,
  parameter int unsigned S_AXI_ID_WIDTH   = 6,
  parameter logic [S_AXI_ADDR_WIDTH-1:0] BASE_ADDR = S_AXI_ADDR_WIDTH'(32'hA0000000),
  parameter int unsigned N_REGS           = 8
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [S_AXI_ID_WIDTH-1:0]              s_axi_awid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [7:0]                             s_axi_awlen,
  input  logic [2:0]                             s_axi_awsize,
  input  logic [1:0]                             s_axi_awburst,
  input  logic                                   s_axi_awlock,
  input  logic [3:0]                             s_axi_awcache,
  input  logic [2:0]                             s_axi_awprot,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                                   s_axi_wlast,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [S_AXI_ID_WIDTH-1:0]              s_axi_bid,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [S_AXI_ID_WIDTH-1:0]              s_axi_arid,
  input  logic [S_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [7:0]                             s_axi_arlen,
  input  logic [2:0]                             s_axi_arsize,
  input  logic [1:0]                             s_axi_arburst,
  input  logic                                   s_axi_arlock,
  input  logic [3:0]                             s_axi_arcache,
  input  logic [2:0]                             s_axi_arprot,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [S_AXI_ID_WIDTH-1:0]              s_axi_rid,
  output logic [S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rlast,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic                                   o_start,
  output logic [(N_REGS-2)*S_AXI_DATA_WIDTH-1:0] o_cfg,
  input  logic                                   i_busy,
  input  logic                                   i_done
);

  localparam int unsigned AW = S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = S_AXI_DATA_WIDTH;
  localparam int unsigned IW = S_AXI_ID_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned XW = $clog2(N_REGS);

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic [IW-1:0] aw_id_q, aw_id_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [SW-1:0] w_strb_q, w_strb_d;
  logic          awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [IW-1:0] bid_q, bid_d, rid_q, rid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          start_q, start_d, done_q, done_d;
  logic [N_REGS-1:2][DW-1:0] cfg_q, cfg_d;

  logic          wr_en, werr, rerr;
  logic [XW-1:0] widx, ridx;
  logic [DW-1:0] rd_val;

  // Word decode relative to BASE_ADDR; out-of-range either errors or aliases on low bits.
  always_comb begin
    widx = XW'((aw_addr_q - BASE_ADDR) >> 2);
    ridx = XW'((s_axi_araddr - BASE_ADDR) >> 2);
`ifdef AXIL_REG_BANK_DECERR_EN
    werr = (aw_addr_q < BASE_ADDR) || (((aw_addr_q - BASE_ADDR) >> 2) >= AW'(N_REGS));
    rerr = (s_axi_araddr < BASE_ADDR) || (((s_axi_araddr - BASE_ADDR) >> 2) >= AW'(N_REGS));
`else
    werr = 1'b0;
    rerr = 1'b0;
`endif
  end

  // Read mux over pre-write register state
  always_comb begin
    rd_val = '0;
    if (ridx == XW'(1)) rd_val[1:0] = {done_q, i_busy};
    for (int unsigned i = 2; i < N_REGS; i++) begin
      if (ridx == XW'(i)) rd_val = cfg_q[i];
    end
    if (rerr) rd_val = '0;
  end

  assign wr_en = aw_held_q && w_held_q;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    start_d   = 1'b0;
    done_d    = done_q || i_done;
    cfg_d     = cfg_q;

    if (s_axi_awvalid && awready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr;
      aw_id_d   = s_axi_awid;
    end
    if (s_axi_wvalid && wready_q) begin
      w_held_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;

    // Commit the write once both halves are held
    if (wr_en) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bid_d     = aw_id_q;
      bresp_d   = werr ? 2'b10 : 2'b00;
      if (!werr) begin
        if (widx == XW'(0) && w_strb_q[0] && w_data_q[0]) start_d = 1'b1;
        if (widx == XW'(1) && w_strb_q[0] && w_data_q[1]) done_d = i_done;
        for (int unsigned i = 2; i < N_REGS; i++) begin
          if (widx == XW'(i)) begin
            for (int unsigned b = 0; b < SW; b++) begin
              if (w_strb_q[b]) cfg_d[i][8*b +: 8] = w_data_q[8*b +: 8];
            end
          end
        end
      end
    end

    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;
    if (s_axi_arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rid_d    = s_axi_arid;
      rresp_d  = rerr ? 2'b10 : 2'b00;
      rdata_d  = rd_val;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_q     <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      done_q    <= done_d;
      cfg_q     <= cfg_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rvalid_q;
  assign o_start       = start_q;
  assign o_cfg         = cfg_q;

  // Burst/attribute fields are irrelevant for single-beat register access
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
                           s_axi_awcache, s_axi_awprot, s_axi_wlast, s_axi_arlen,
                           s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                           s_axi_arprot};

endmodule

// File: tb/tb_axil_reg_bank.sv
// Scoreboard bench for axil_reg_bank: directed writes/reads, B/R checked by a separate monitor.
module tb_axil_reg_bank;

  localparam int unsigned AW = 40;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 6;
  localparam int unsigned NR = 8;
  localparam logic [AW-1:0] BASE = 40'hA0000000;
`ifdef AXIL_REG_BANK_DECERR_EN
  localparam logic [1:0] OOR_RESP  = 2'b10;
  localparam int         OOR_START = 0;
`else
  localparam logic [1:0] OOR_RESP  = 2'b00;
  localparam int         OOR_START = 1;
`endif

  logic clk = 1'b0;
  logic rstn;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic          o_start, i_busy, i_done;
  logic [(NR-2)*DW-1:0] o_cfg;

  axil_reg_bank #(
    .S_AXI_ADDR_WIDTH(AW), .S_AXI_DATA_WIDTH(DW), .S_AXI_ID_WIDTH(IW),
    .BASE_ADDR(BASE), .N_REGS(NR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_start(o_start), .o_cfg(o_cfg), .i_busy(i_busy), .i_done(i_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t be;
  r_exp_t re;
  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] cfg(input int i);
    return o_cfg[(i-2)*DW +: DW];
  endfunction

  // Monitor: every B/R handshake pops one expectation
  always @(negedge clk) begin
    if (o_start) start_cnt++;
    if (rstn && s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) ck("b_unexpected", 64'(1), 64'(0));
      else begin
        be = bq.pop_front();
        ck("bid", 64'(s_axi_bid), 64'(be.id));
        ck("bresp", 64'(s_axi_bresp), 64'(be.resp));
      end
    end
    if (rstn && s_axi_rvalid && s_axi_rready) begin
      if (rq.size() == 0) ck("r_unexpected", 64'(1), 64'(0));
      else begin
        re = rq.pop_front();
        ck("rid", 64'(s_axi_rid), 64'(re.id));
        ck("rdata", 64'(s_axi_rdata), 64'(re.data));
        ck("rresp", 64'(s_axi_rresp), 64'(re.resp));
        ck("rlast", 64'(s_axi_rlast), 64'(1));
      end
    end
  end

  task automatic send_aw(input logic [AW-1:0] a, input logic [IW-1:0] id);
    s_axi_awaddr = a; s_axi_awid = id; s_axi_awvalid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (s_axi_awready) begin
        @(posedge clk); #1; s_axi_awvalid = 1'b0; return;
      end
    end
    ck("aw_timeout", 64'(0), 64'(1));
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [3:0] strb);
    s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (s_axi_wready) begin
        @(posedge clk); #1; s_axi_wvalid = 1'b0; return;
      end
    end
    ck("w_timeout", 64'(0), 64'(1));
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id);
    s_axi_araddr = a; s_axi_arid = id; s_axi_arvalid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        @(posedge clk); #1; s_axi_arvalid = 1'b0;
        ck("r_latency", 64'(s_axi_rvalid), 64'(1));
        return;
      end
    end
    ck("ar_timeout", 64'(0), 64'(1));
    s_axi_arvalid = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] strb,
                       input logic [IW-1:0] id, input logic [1:0] resp);
    bq.push_back('{id: id, resp: resp});
    fork
      send_aw(a, id);
      send_w(d, strb);
    join
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [IW-1:0] id,
                      input logic [DW-1:0] d, input logic [1:0] resp);
    rq.push_back('{id: id, data: d, resp: resp});
    send_ar(a, id);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = (bq.size() == 0) && (rq.size() == 0) && !s_axi_bvalid && !s_axi_rvalid;
    end
    if (!ok) ck("idle_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; i_busy = 1'b0; i_done = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd1; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b1;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    ck("rst_awready", 64'(s_axi_awready), 64'(0));
    ck("rst_wready", 64'(s_axi_wready), 64'(0));
    ck("rst_arready", 64'(s_axi_arready), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    ck("post_rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));
    ck("post_rst_valid", 64'({s_axi_bvalid, s_axi_rvalid, o_start}), 64'(0));
    ck("post_rst_cfg", 64'(o_cfg == '0), 64'(1));
    ck("post_rst_rdata", 64'(s_axi_rdata), 64'(0));

    // Basic write/read of CFG reg 2
    write(BASE + 40'h8, 32'hDEADBEEF, 4'hF, 6'd1, 2'b00);
    wait_idle();
    ck("cfg2", 64'(cfg(2)), 64'(32'hDEADBEEF));
    read(BASE + 40'h8, 6'd2, 32'hDEADBEEF, 2'b00);
    wait_idle();

    // Byte strobes
    write(BASE + 40'hC, 32'h11223344, 4'h5, 6'd3, 2'b00);
    wait_idle();
    ck("cfg3_strb", 64'(cfg(3)), 64'(32'h00220044));
    read(BASE + 40'hC, 6'd4, 32'h00220044, 2'b00);
    wait_idle();

    // AW first, W late, B back-pressured
    s_axi_bready = 1'b0;
    bq.push_back('{id: 6'h2A, resp: 2'b00});
    send_aw(BASE + 40'h10, 6'h2A);
    repeat (5) @(posedge clk);
    #1;
    ck("aw_held_blocks", 64'(s_axi_awready), 64'(0));
    send_w(32'h12345678, 4'hF);
    for (int t = 0; t < 8 && !s_axi_bvalid; t++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ck("b_hold_valid", 64'(s_axi_bvalid), 64'(1));
      ck("b_hold_id", 64'(s_axi_bid), 64'(6'h2A));
      ck("b_hold_awready", 64'(s_axi_awready), 64'(0));
    end
    @(posedge clk); #1;
    s_axi_bready = 1'b1;
    wait_idle();
    ck("cfg4", 64'(cfg(4)), 64'(32'h12345678));

    // CTRL start pulse
    start_cnt = 0;
    write(BASE, 32'h1, 4'h1, 6'd5, 2'b00);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    ck("start_once", 64'(start_cnt), 64'(1));
    write(BASE, 32'h0, 4'hF, 6'd6, 2'b00);
    write(BASE, 32'h1, 4'h2, 6'd7, 2'b00);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    ck("start_no_extra", 64'(start_cnt), 64'(1));
    read(BASE, 6'd8, 32'h0, 2'b00);
    wait_idle();

    // STATUS: sticky done, live busy, clear vs simultaneous done
    read(BASE + 40'h4, 6'd9, 32'h0, 2'b00);
    wait_idle();
    i_done = 1'b1; @(posedge clk); #1; i_done = 1'b0;
    read(BASE + 40'h4, 6'd10, 32'h2, 2'b00);
    wait_idle();
    i_busy = 1'b1;
    read(BASE + 40'h4, 6'd11, 32'h3, 2'b00);
    wait_idle();
    i_busy = 1'b0;
    write(BASE + 40'h4, 32'h2, 4'h1, 6'd12, 2'b00);
    i_done = 1'b1; @(posedge clk); #1; i_done = 1'b0;
    wait_idle();
    read(BASE + 40'h4, 6'd13, 32'h2, 2'b00);
    wait_idle();
    write(BASE + 40'h4, 32'h2, 4'h1, 6'd14, 2'b00);
    wait_idle();
    read(BASE + 40'h4, 6'd15, 32'h0, 2'b00);
    wait_idle();

    // Out-of-range: error or alias onto CTRL depending on build
    start_cnt = 0;
    write(BASE + 40'h40, 32'h1, 4'hF, 6'd16, OOR_RESP);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    ck("oor_start", 64'(start_cnt), 64'(OOR_START));
    ck("oor_cfg2", 64'(cfg(2)), 64'(32'hDEADBEEF));
    ck("oor_cfg3", 64'(cfg(3)), 64'(32'h00220044));
    ck("oor_cfg4", 64'(cfg(4)), 64'(32'h12345678));
    read(BASE + 40'h40, 6'd17, 32'h0, OOR_RESP);
    wait_idle();
    read(BASE - 40'h4, 6'd18, 32'h0, OOR_RESP);
    wait_idle();

    // Read and write of reg 5 committing on the same edge: read sees old value
    write(BASE + 40'h14, 32'hAAAA0000, 4'hF, 6'd19, 2'b00);
    wait_idle();
    write(BASE + 40'h14, 32'hBBBB1111, 4'hF, 6'd20, 2'b00);
    read(BASE + 40'h14, 6'd21, 32'hAAAA0000, 2'b00);
    wait_idle();
    ck("cfg5_new", 64'(cfg(5)), 64'(32'hBBBB1111));

    // Reset with B and R both pending
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    write(BASE + 40'h18, 32'h55, 4'hF, 6'd22, 2'b00);
    read(BASE + 40'h8, 6'd23, 32'hDEADBEEF, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    ck("pend_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(2'b11));
    rstn = 1'b0;
    bq.delete(); rq.delete();
    repeat (2) @(posedge clk);
    #1;
    ck("rst2_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(0));
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    rstn = 1'b1;
    @(posedge clk); #1;
    ck("rst2_valids", 64'({s_axi_bvalid, s_axi_rvalid}), 64'(0));
    ck("rst2_cfg", 64'(o_cfg == '0), 64'(1));
    ck("rst2_ready_up", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'(3'b111));
    write(BASE + 40'h8, 32'hCAFE0001, 4'hF, 6'd24, 2'b00);
    wait_idle();
    read(BASE + 40'h8, 6'd25, 32'hCAFE0001, 2'b00);
    wait_idle();
    ck("rst2_cfg2", 64'(cfg(2)), 64'(32'hCAFE0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
